// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the stalling instruction memory, drives the IF/ID latch write side.
// Latency: zero-wait memory delivers one instruction per cycle; a slow access shows as fetch-stall bubbles.
// Backpressure: stall_in holds the latch; a word that arrives while stalled is parked in a one-entry buffer.
// Optional perf counters (fetched_cnt, stall_cnt) are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    input  logic        halt_in,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    input  logic [15:0] imem_data,
    input  logic        imem_stall,
    input  logic        imem_done,
    output logic [15:0] instruction_out,
    output logic [15:0] pc_plus2_out,
    output logic        latch_en,
    output logic        flush_out,
    output logic        fetch_stall_out,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] fetched_cnt,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALTED} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt;
    logic [15:0] buffer, buffer_nxt;
    logic [15:0] req_addr;
    logic        drop, drop_nxt;
    logic [15:0] pc_plus2;
    logic        ret;
    logic        outstanding;
    logic        rd_c, le_c, flush_c, fstall_c;
    logic [15:0] instr_c;

    assign pc_plus2 = pc + 16'd2;
    // A busy memory cannot be returning data, so done is only trusted when not stalled.
    assign ret = imem_done & ~imem_stall;
    // drop is only ever set while an access is in flight (WAIT or HALTED).
    assign outstanding = (state == S_WAIT) || drop;

    // Next-state and per-cycle latch outputs; redirect first, then a pending drop, then halt, then normal fetch.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        buffer_nxt = buffer;
        drop_nxt   = drop;
        rd_c       = 1'b0;
        le_c       = 1'b0;
        flush_c    = 1'b0;
        fstall_c   = 1'b0;
        instr_c    = NOP_INSTR;
        if (redirect_valid) begin
            flush_c = 1'b1;
            le_c    = 1'b1;
            pc_nxt  = redirect_pc;
            if (outstanding && !ret) begin
                state_nxt = S_WAIT;
                drop_nxt  = 1'b1;
            end else begin
                state_nxt = S_FETCH;
                drop_nxt  = 1'b0;
            end
        end else if (drop) begin
            if (ret) begin
                drop_nxt = 1'b0;
            end
            if (halt_in || state == S_HALTED) begin
                state_nxt = S_HALTED;
            end else if (ret) begin
                state_nxt = S_FETCH;
            end else begin
                fstall_c = 1'b1;
                le_c     = ~stall_in;
            end
        end else if (halt_in) begin
            state_nxt = S_HALTED;
            if (state == S_WAIT && !ret) begin
                drop_nxt = 1'b1;
            end
        end else begin
            case (state)
                S_FETCH, S_WAIT: begin
                    rd_c = (state == S_FETCH);
                    if (ret) begin
                        if (stall_in) begin
                            buffer_nxt = imem_data;
                            state_nxt  = S_HOLD;
                        end else begin
                            le_c      = 1'b1;
                            instr_c   = imem_data;
                            pc_nxt    = pc_plus2;
                            state_nxt = S_FETCH;
                        end
                    end else begin
                        fstall_c  = 1'b1;
                        le_c      = ~stall_in;
                        state_nxt = S_WAIT;
                    end
                end
                S_HOLD: begin
                    instr_c = buffer;
                    le_c    = ~stall_in;
                    if (!stall_in) begin
                        pc_nxt    = pc_plus2;
                        state_nxt = S_FETCH;
                    end
                end
                S_HALTED: begin
                    state_nxt = S_HALTED;
                end
                default: begin
                    state_nxt = S_FETCH;
                end
            endcase
        end
    end

    // State, PC, hold buffer, drop flag and the address of the access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            buffer   <= 16'h0000;
            drop     <= 1'b0;
            req_addr <= RESET_PC;
        end else begin
            state  <= state_nxt;
            pc     <= pc_nxt;
            buffer <= buffer_nxt;
            drop   <= drop_nxt;
            if (rd_c) begin
                req_addr <= pc;
            end
        end
    end

    // While reset is asserted every output shows its idle value immediately.
    assign imem_addr       = (state == S_FETCH) ? pc : req_addr;
    assign imem_rd         = rst & rd_c;
    assign latch_en        = rst & le_c;
    assign flush_out       = rst & flush_c;
    assign fetch_stall_out = rst & fstall_c;
    assign halted          = rst & (state == S_HALTED);
    assign instruction_out = rst ? instr_c : NOP_INSTR;
    assign pc_plus2_out    = rst ? pc_plus2 : 16'h0000;

`ifdef FETCH_PERF_CNT_EN
    logic deliver;
    assign deliver = le_c & ~fstall_c & ~flush_c;

    // Saturating counts of real instructions written and of cycles spent waiting on memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_cnt <= 16'h0000;
            stall_cnt   <= 16'h0000;
        end else begin
            if (deliver && fetched_cnt != 16'hFFFF) begin
                fetched_cnt <= fetched_cnt + 16'd1;
            end
            if (state == S_WAIT && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed walk through the fetch scenarios, then randomized control and memory latency.
// A memory model answers each request after a chosen latency; a behavioural model predicts every output.
// All controls change on the falling edge; outputs are sampled 2 time units later.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0800;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        halt_in = 1'b0;
    logic [15:0] imem_addr;
    logic        imem_rd;
    logic [15:0] imem_data = 16'h0000;
    logic        imem_stall = 1'b0;
    logic        imem_done = 1'b0;
    logic [15:0] instruction_out;
    logic [15:0] pc_plus2_out;
    logic        latch_en;
    logic        flush_out;
    logic        fetch_stall_out;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_cnt;
    logic [15:0] stall_cnt;
    int          m_fetched;
    int          m_waits;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt_in(halt_in), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .imem_stall(imem_stall), .imem_done(imem_done),
        .instruction_out(instruction_out), .pc_plus2_out(pc_plus2_out), .latch_en(latch_en),
        .flush_out(flush_out), .fetch_stall_out(fetch_stall_out), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
        , .fetched_cnt(fetched_cnt), .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model
    logic        mem_busy = 1'b0;
    logic [15:0] mem_addr = 16'h0000;
    int          mem_left = 0;
    int          lat_fixed = 0;

    // behavioural model
    logic [15:0] m_pc = RESET_PC;
    logic        m_held = 1'b0;
    logic [15:0] m_held_word = 16'h0000;
    logic        m_out = 1'b0;
    logic [15:0] m_out_addr = 16'h0000;
    logic        m_discard = 1'b0;
    logic        m_halted = 1'b0;

    // last sampled outputs
    logic [15:0] obs_addr, obs_ins, obs_p2;
    logic        obs_rd, obs_le, obs_fl, obs_fs, obs_hl;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA001 + {1'b0, a[15:1]};
    endfunction

    function automatic int next_lat();
        int r;
        if (lat_fixed >= 0) return lat_fixed;
        r = int'($urandom_range(0, 5));
        return (r > 3) ? 0 : r;
    endfunction

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_held = 0; m_out = 0; m_discard = 0; m_halted = 0;
        mem_busy = 0; mem_left = 0; imem_done = 0; imem_stall = 0;
`ifdef FETCH_PERF_CNT_EN
        m_fetched = 0; m_waits = 0;
`endif
    endtask

    // One clock cycle: drive controls, answer memory, compare against the model, advance the model.
    task automatic step(input logic s, input logic r, input logic [15:0] rp, input logic h);
        logic        done, e_rd, e_le, e_fl, e_fs, e_hl, c_ins, c_fs, c_p2, c_addr;
        logic [15:0] e_ins, e_p2, e_addr, word;
        @(negedge clk);
        stall_in = s; redirect_valid = r; redirect_pc = rp; halt_in = h;
        #1;
        cmp("one_outstanding", {15'd0, imem_rd & mem_busy}, 16'd0);
        if (imem_rd && !mem_busy) begin
            mem_busy = 1; mem_addr = imem_addr; mem_left = next_lat();
        end
        if (mem_busy && mem_left == 0) begin
            imem_done = 1; imem_stall = 0; imem_data = mem_word(mem_addr);
        end else begin
            imem_done = 0; imem_stall = mem_busy; imem_data = 16'($urandom);
        end
        done = imem_done;
        #1;
        obs_addr = imem_addr; obs_ins = instruction_out; obs_p2 = pc_plus2_out;
        obs_rd = imem_rd; obs_le = latch_en; obs_fl = flush_out; obs_fs = fetch_stall_out; obs_hl = halted;

        e_hl = m_halted;
        e_rd = !m_halted && !m_held && !m_out && !r && !h;
        c_addr = e_rd || m_out;
        e_addr = m_out ? m_out_addr : m_pc;
        word = mem_word(e_addr);
        e_le = 0; e_fl = 0; e_fs = 0; e_ins = NOP_INSTR; e_p2 = m_pc + 16'd2;
        c_ins = 0; c_fs = 0; c_p2 = 0;
`ifdef FETCH_PERF_CNT_EN
        if (m_out && !m_halted) m_waits++;
`endif
        if (r) begin
            e_fl = 1; e_le = 1; c_ins = 1; c_fs = 1;
            m_pc = rp; m_held = 0; m_halted = 0;
            if (m_out && !done) m_discard = 1;
            else begin m_out = 0; m_discard = 0; end
        end else if (m_discard) begin
            if (!(h || m_halted) && !done) begin
                e_le = !s; e_fs = 1; c_fs = 1; c_ins = 1;
            end
            if (done) begin m_out = 0; m_discard = 0; end
            if (h) m_halted = 1;
        end else if (h) begin
            m_halted = 1; m_held = 0;
            if (m_out && !done) m_discard = 1;
            else m_out = 0;
        end else if (m_halted) begin
            e_le = 0;
        end else if (m_held) begin
            e_ins = m_held_word; c_ins = 1; c_fs = 1; e_le = !s;
            if (!s) begin
                c_p2 = 1; m_pc = m_pc + 16'd2; m_held = 0;
`ifdef FETCH_PERF_CNT_EN
                m_fetched++;
`endif
            end
        end else begin
            if (done) begin
                m_out = 0;
                if (s) begin
                    m_held = 1; m_held_word = word;
                end else begin
                    e_le = 1; e_ins = word; c_ins = 1; c_fs = 1; c_p2 = 1;
                    m_pc = m_pc + 16'd2;
`ifdef FETCH_PERF_CNT_EN
                    m_fetched++;
`endif
                end
            end else begin
                if (e_rd) begin m_out = 1; m_out_addr = m_pc; end
                e_le = !s; e_fs = 1; c_fs = 1; c_ins = 1;
            end
        end

        cmp("imem_rd", {15'd0, obs_rd}, {15'd0, e_rd});
        cmp("latch_en", {15'd0, obs_le}, {15'd0, e_le});
        cmp("flush_out", {15'd0, obs_fl}, {15'd0, e_fl});
        cmp("halted", {15'd0, obs_hl}, {15'd0, e_hl});
        if (c_addr) cmp("imem_addr", obs_addr, e_addr);
        if (c_ins) cmp("instruction_out", obs_ins, e_ins);
        if (c_fs) cmp("fetch_stall_out", {15'd0, obs_fs}, {15'd0, e_fs});
        if (c_p2) cmp("pc_plus2_out", obs_p2, e_p2);

        if (mem_busy) begin
            if (mem_left == 0) mem_busy = 0;
            else mem_left--;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_rd"}, {15'd0, imem_rd}, 16'd0);
        cmp({tag, "_le"}, {15'd0, latch_en}, 16'd0);
        cmp({tag, "_flush"}, {15'd0, flush_out}, 16'd0);
        cmp({tag, "_fstall"}, {15'd0, fetch_stall_out}, 16'd0);
        cmp({tag, "_halted"}, {15'd0, halted}, 16'd0);
        cmp({tag, "_instr"}, instruction_out, NOP_INSTR);
        cmp({tag, "_pc2"}, pc_plus2_out, 16'h0000);
    endtask

    initial begin
        model_reset();
        #3;
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1;

        // zero-wait stream
        lat_fixed = 0;
        step(0, 0, 0, 0);
        cmp("zw0_addr", obs_addr, 16'h0000); cmp("zw0_ins", obs_ins, 16'hA001); cmp("zw0_p2", obs_p2, 16'h0002);
        step(0, 0, 0, 0);
        cmp("zw1_addr", obs_addr, 16'h0002); cmp("zw1_ins", obs_ins, 16'hA002); cmp("zw1_le", {15'd0, obs_le}, 16'd1);
        step(0, 0, 0, 0);
        cmp("zw2_addr", obs_addr, 16'h0004); cmp("zw2_p2", obs_p2, 16'h0006);

        // three-cycle memory latency at PC=6
        lat_fixed = 3;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            cmp("slow_bubble_ins", obs_ins, NOP_INSTR);
            cmp("slow_bubble_fs", {15'd0, obs_fs}, 16'd1);
            cmp("slow_addr", obs_addr, 16'h0006);
        end
        step(0, 0, 0, 0);
        cmp("slow_ins", obs_ins, 16'hA004); cmp("slow_p2", obs_p2, 16'h0008); cmp("slow_addr_done", obs_addr, 16'h0006);

        // data returns at PC=8 under a two-cycle hazard stall
        lat_fixed = 0;
        step(1, 0, 0, 0);
        cmp("hold0_le", {15'd0, obs_le}, 16'd0);
        step(1, 0, 0, 0);
        cmp("hold1_le", {15'd0, obs_le}, 16'd0);
        step(0, 0, 0, 0);
        cmp("hold_ins", obs_ins, 16'hA005); cmp("hold_p2", obs_p2, 16'h000A); cmp("hold_le", {15'd0, obs_le}, 16'd1);
        step(0, 0, 0, 0);
        cmp("after_hold_addr", obs_addr, 16'h000A); cmp("after_hold_rd", {15'd0, obs_rd}, 16'd1);

        // redirect during an outstanding access
        lat_fixed = 2;
        step(0, 0, 0, 0);
        step(0, 1, 16'h0040, 0);
        cmp("redir_flush", {15'd0, obs_fl}, 16'd1); cmp("redir_ins", obs_ins, NOP_INSTR); cmp("redir_le", {15'd0, obs_le}, 16'd1);
        lat_fixed = 0;
        step(0, 0, 0, 0);
        cmp("dropped_le", {15'd0, obs_le}, 16'd0);
        step(0, 0, 0, 0);
        cmp("redir_addr", obs_addr, 16'h0040); cmp("redir_data", obs_ins, 16'hA021);

        // halt, idle, then leave by redirect
        step(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            cmp("halt_rd", {15'd0, obs_rd}, 16'd0);
            cmp("halt_flag", {15'd0, obs_hl}, 16'd1);
        end
        step(0, 1, 16'h0100, 0);
        step(0, 0, 0, 0);
        cmp("resume_addr", obs_addr, 16'h0100); cmp("resume_halted", {15'd0, obs_hl}, 16'd0);

        // PC wrap, then asynchronous reset in the middle of a slow access
        step(0, 1, 16'hFFFE, 0);
        step(0, 0, 0, 0);
        cmp("wrap_addr", obs_addr, 16'hFFFE); cmp("wrap_p2", obs_p2, 16'h0000);
        step(0, 0, 0, 0);
        cmp("wrapped_addr", obs_addr, 16'h0000);
        lat_fixed = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        #1 rst = 0;
        model_reset();
        #1;
        check_reset_outputs("midreset");
        @(posedge clk);
        #1 rst = 1;
        lat_fixed = 0;
        step(0, 0, 0, 0);
        cmp("restart_addr", obs_addr, RESET_PC); cmp("restart_ins", obs_ins, 16'hA001);

        // randomized control and latency
        lat_fixed = -1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 5,
                 16'($urandom) & 16'hFFFE, $urandom_range(0, 99) < 3);
        end

`ifdef FETCH_PERF_CNT_EN
        #1;
        cmp("fetched_cnt", fetched_cnt, (m_fetched > 65535) ? 16'hFFFF : 16'(m_fetched));
        cmp("stall_cnt", stall_cnt, (m_waits > 65535) ? 16'hFFFF : 16'(m_waits));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
